// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 refresh scheduler: FSM state encoding,
// SSD1306 addressing opcodes and default framebuffer geometry.
package oled_pkg;

    // Scheduler states: IDLE waits for work, HOST forwards one command byte,
    // PRE streams the window-address preamble, FETCH covers RAM read latency,
    // SEND offers one framebuffer byte as display data.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOST  = 3'd1,
        PRE   = 3'd2,
        FETCH = 3'd3,
        SEND  = 3'd4
    } state_t;

    // SSD1306 window addressing opcodes
    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

    // Default panel geometry (128x64, 8 pages of 8 rows)
    localparam int OLED_COLS  = 128;
    localparam int OLED_PAGES = 8;
    localparam int FB_BYTES   = OLED_COLS * OLED_PAGES;

    // Number of command bytes sent before the framebuffer data
    localparam int PRE_LEN = 6;

endpackage

// File: rtl/oled_preamble_rom.sv
// Window-address preamble lookup: maps preamble index 0..5 to the command
// byte that sets the full column and page range before a frame.
module oled_preamble_rom
    import oled_pkg::*;
#(
    parameter int COLS  = OLED_COLS,
    parameter int PAGES = OLED_PAGES
) (
    input  logic [2:0] idx,
    output logic [7:0] data
);

    // Column range 0..COLS-1, then page range 0..PAGES-1
    always_comb begin
        data = 8'h00;
        case (idx)
            3'd0:    data = CMD_COL_ADDR;
            3'd1:    data = 8'h00;
            3'd2:    data = 8'(COLS - 1);
            3'd3:    data = CMD_PAGE_ADDR;
            3'd4:    data = 8'h00;
            3'd5:    data = 8'(PAGES - 1);
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_refresh_sched.sv
// Arbiter between single host command bytes and full-frame refreshes for one
// shared SSD1306 SPI byte sender (valid/ready byte interface).
// Optional build macro OLED_AUTO_REFRESH_EN adds a free-running refresh timer
// that raises an internal refresh request every REFRESH_PERIOD cycles.
module oled_refresh_sched
    import oled_pkg::*;
#(
    parameter int COLS  = OLED_COLS,
    parameter int PAGES = OLED_PAGES
`ifdef OLED_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_PERIOD = 900000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_req,
    input  logic       host_cmd_valid,
    input  logic [7:0] host_cmd_data,
    output logic       host_cmd_ready,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_rdata,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    input  logic       byte_ready,
    output logic       busy,
    output logic       frame_done
);

    // Last framebuffer address and last preamble index
    localparam logic [9:0] FB_LAST  = 10'(COLS * PAGES - 1);
    localparam logic [2:0] PRE_LAST = 3'(PRE_LEN - 1);

    state_t     state_reg,     state_next;
    logic [2:0] pre_idx_reg,   pre_idx_next;
    logic [9:0] fb_addr_reg,   fb_addr_next;
    logic       pending_reg,   pending_next;
    logic [7:0] host_data_reg, host_data_next;

    logic       xfer;
    logic       consume;
    logic       auto_tick;
    logic [7:0] pre_byte;

    oled_preamble_rom #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_preamble_rom (
        .idx  (pre_idx_reg),
        .data (pre_byte)
    );

`ifdef OLED_AUTO_REFRESH_EN
    localparam int TICK_W = $clog2(REFRESH_PERIOD + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_PERIOD - 1);

    logic [TICK_W-1:0] tick_cnt_reg;

    assign auto_tick = (tick_cnt_reg == TICK_LAST);

    // Free-running refresh timer, keeps counting while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (auto_tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end
`else
    assign auto_tick = 1'b0;
`endif

    // A byte moves to the SPI sender whenever it is offered and accepted
    assign xfer = byte_valid && byte_ready;

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pre_idx_reg   <= '0;
            fb_addr_reg   <= '0;
            pending_reg   <= 1'b0;
            host_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pre_idx_reg   <= pre_idx_next;
            fb_addr_reg   <= fb_addr_next;
            pending_reg   <= pending_next;
            host_data_reg <= host_data_next;
        end
    end

    // Next-state logic: host wins only from IDLE, frames run to completion
    always_comb begin
        state_next     = state_reg;
        pre_idx_next   = pre_idx_reg;
        fb_addr_next   = fb_addr_reg;
        host_data_next = host_data_reg;
        consume        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (host_cmd_valid) begin
                    // Latch the command so the offered byte cannot change
                    host_data_next = host_cmd_data;
                    state_next     = HOST;
                end else if (refresh_req || pending_reg) begin
                    consume      = 1'b1;
                    pre_idx_next = '0;
                    state_next   = PRE;
                end
            end
            HOST: begin
                if (xfer) begin
                    state_next = IDLE;
                end
            end
            PRE: begin
                if (xfer) begin
                    if (pre_idx_reg == PRE_LAST) begin
                        fb_addr_next = '0;
                        state_next   = FETCH;
                    end else begin
                        pre_idx_next = pre_idx_reg + 1'b1;
                    end
                end
            end
            FETCH: begin
                // fb_addr was presented this cycle; data is valid next cycle
                state_next = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (fb_addr_reg == FB_LAST) begin
                        state_next = IDLE;
                    end else begin
                        fb_addr_next = fb_addr_reg + 1'b1;
                        state_next   = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Requests that cannot start now collapse into one pending frame;
        // a timer wrap in the consuming cycle still counts as a new request.
        if (consume) begin
            pending_next = auto_tick;
        end else begin
            pending_next = pending_reg || refresh_req || auto_tick;
        end
    end

    // Outputs decode from registered state, so reset clears them at once
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_dc    = 1'b0;
        case (state_reg)
            HOST: begin
                byte_valid = 1'b1;
                byte_data  = host_data_reg;
            end
            PRE: begin
                byte_valid = 1'b1;
                byte_data  = pre_byte;
            end
            SEND: begin
                // RAM output is registered and fb_addr holds, so it is stable
                byte_valid = 1'b1;
                byte_data  = fb_rdata;
                byte_dc    = 1'b1;
            end
            default: begin
                byte_valid = 1'b0;
            end
        endcase
    end

    assign host_cmd_ready = (state_reg == HOST) && byte_ready;
    assign frame_done     = (state_reg == SEND) && byte_ready && (fb_addr_reg == FB_LAST);
    assign busy           = (state_reg != IDLE);
    assign fb_addr        = fb_addr_reg;

endmodule

// File: doc/oled_refresh_sched.md
Name: oled_refresh_sched

Overview:
Scheduler that shares one SSD1306 SPI byte serializer between two requesters: single-byte host commands and full-frame refresh from a 1024-byte framebuffer RAM.
- A refresh first sends the window-address preamble, then streams every framebuffer byte as data (dc=1).
- Sits between the top-level controller logic and the bit-level SPI sender, which exposes a valid/ready byte interface.

Parameters:
COLS, 128, display columns per page
PAGES, 8, display pages (8 rows each)
REFRESH_PERIOD, 900000, clk cycles between automatic refreshes (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
refresh_req  in  1  one-cycle pulse requesting a full-frame refresh
host_cmd_valid  in  1  host command byte offered
host_cmd_data  in  8  host command byte
host_cmd_ready  out  1  host command byte accepted this cycle
fb_addr  out  10  framebuffer read address
fb_rdata  in  8  framebuffer read data, valid 1 cycle after fb_addr
byte_valid  out  1  byte offered to SPI sender
byte_data  out  8  byte to serialize
byte_dc  out  1  0 = command, 1 = data
byte_ready  in  1  SPI sender accepts the byte
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last framebuffer byte is accepted

Behaviour:
- Reset values (asynchronous, active-high): all outputs 0, state IDLE, counters 0, pending flag 0.
- Byte handshake:
  - A transfer occurs on a cycle where byte_valid && byte_ready.
  - Once byte_valid rises, byte_data and byte_dc hold stable until that transfer.
  - byte_valid drops the cycle after the transfer unless the next byte is immediately available.
- States:
  - IDLE: if host_cmd_valid, go to HOST. Else if refresh_req or pending, clear pending and go to PRE.
  - HOST:
    - Present host_cmd_data with dc=0.
    - On transfer: pulse host_cmd_ready for the same cycle, return to IDLE.
  - PRE:
    - Send 6 preamble bytes with dc=0: 0x21, 0x00, COLS-1, 0x22, 0x00, PAGES-1.
    - A 3-bit index advances on each transfer.
    - After the 6th transfer, set fb_addr=0 and go to FETCH.
  - FETCH: wait one cycle for RAM latency, then go to SEND.
  - SEND:
    - Present fb_rdata (registered) with dc=1.
    - On transfer: if fb_addr == COLS*PAGES-1, pulse frame_done and go to IDLE. Otherwise increment fb_addr and go to FETCH.
- Arbitration:
  - Host commands win only in IDLE; a frame is never interrupted.
  - refresh_req arriving while busy sets the pending flag. Multiple requests collapse to one.
  - refresh_req in the same cycle as the final frame transfer also sets pending.
- host_cmd_ready is never high outside HOST.
- fb_addr is 10 bits with no wrap past 1023; its terminal value is exactly COLS*PAGES-1.
- Asserting rst mid-frame aborts immediately to IDLE, drops byte_valid, and clears pending. The SPI sender must be reset with the same rst.

Optional Feature:
OLED_AUTO_REFRESH_EN
- Defined: a free-running counter counts 0..REFRESH_PERIOD-1 and, on wrap, sets the pending flag as an internal refresh request. The counter keeps running while busy. The counter resets to 0.
- Undefined: no counter is present, and refreshes happen only via refresh_req.

Decomposition:
- Shared package oled_pkg holds:
  - state encoding localparams: IDLE, HOST, PRE, FETCH, SEND;
  - SSD1306 opcode constants: CMD_COL_ADDR = 0x21, CMD_PAGE_ADDR = 0x22;
  - FB_BYTES = COLS*PAGES.
- One natural sub-module: oled_preamble_rom, combinational index 0..5 -> byte.

Test Plan:
- Reset then idle: rst pulse, no requests -> all outputs 0, busy=0 for 100 cycles.
- Host command: host_cmd_valid=1, data=0xAF, byte_ready after 3 cycles -> byte_data=0xAF, dc=0, held stable; host_cmd_ready pulses on the transfer cycle only.
- Full frame: refresh_req pulse, byte_ready always 1, RAM pattern addr[7:0] -> exactly 6 dc=0 bytes 21,00,7F,22,00,07, then 1024 dc=1 bytes matching the pattern in order; frame_done once on byte 1024.
- Arbitration: host_cmd_valid and refresh_req in the same IDLE cycle -> host byte first, then the frame. Host request raised mid-frame -> waits until frame_done.
- Pending collapse: 3 refresh_req pulses during a frame -> exactly one further frame, then IDLE.
- Backpressure/reset: random byte_ready stalls -> data stable while valid. rst at byte 500 -> outputs 0 the cycle of assertion; a new refresh starts from the preamble.
